idex_hazard_ctrl: RTL
=====================

// Module: idex_hazard_ctrl
// PURPOSE
//  Consumer-side control for the ID/EX pipeline register: reads the ID/EX, EX/MEM and MEM/WB
//  destination/control fields and drives stall, bubble, flush and operand-forwarding selects.
//  Sits beside the decode stage; its outputs gate IF/ID, the PC and the ID/EX ctrl input.
//  Small FSM sequences load-use stalls, taken-branch flushes and data-memory wait freezes.
// PARAMETERS
//  CTRL_WIDTH     16  width of pipeline ctrl vector (matches ID/EX ctrl_q2)
//  MEM_READ_BIT   3   index of mem-read flag within ctrl vector
//  REG_WRITE_BIT  0   index of reg-write flag within ctrl vector
// PORTS
//  clk            in   1           core clock
//  rst            in   1           asynchronous reset, active-high
//  id_rs1_i       in   5           rs1 of instruction in ID
//  id_rs2_i       in   5           rs2 of instruction in ID
//  id_rs_used_i   in   2           [0]=rs1 read, [1]=rs2 read by ID instruction
//  idex_wr_reg_i  in   5           ID/EX destination register
//  idex_ctrl_i    in   CTRL_WIDTH  ID/EX ctrl vector
//  exmem_wr_reg_i in   5           EX/MEM destination register
//  exmem_ctrl_i   in   CTRL_WIDTH  EX/MEM ctrl vector
//  memwb_wr_reg_i in   5           MEM/WB destination register
//  memwb_ctrl_i   in   CTRL_WIDTH  MEM/WB ctrl vector
//  branch_taken_i in   1           EX resolved a taken branch/jump this cycle
//  dmem_req_i     in   1           EX/MEM instruction accesses data memory
//  dmem_ready_i   in   1           data memory completes access this cycle
//  pc_hold_o      out  1           hold PC
//  ifid_hold_o    out  1           hold IF/ID
//  ifid_flush_o   out  1           load NOP into IF/ID
//  idex_bubble_o  out  1           force ID/EX ctrl input to 0
//  pipe_freeze_o  out  1           hold ID/EX, EX/MEM, MEM/WB
//  fwd_a_sel_o    out  2           EX operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  fwd_b_sel_o    out  2           EX operand B: same encoding
// BEHAVIOUR
//  - States RUN, LOAD_STALL, FLUSH, MEM_WAIT; state reg async-reset to RUN. Outputs combinational
//    from state+inputs; while rst high all outputs 0.
//  - Priority per cycle: MEM_WAIT cond > branch flush > load-use > none.
//  - MEM_WAIT cond: dmem_req_i & ~dmem_ready_i -> pc_hold, ifid_hold, pipe_freeze=1, enter/stay
//    MEM_WAIT; cycle ready=1 -> freeze drops, outputs per lower priorities, next RUN. No timeout.
//  - Branch: branch_taken_i (not frozen) -> ifid_flush=1, idex_bubble=1, next FLUSH (1 cycle,
//    outputs 0 unless new conditions) -> RUN. Suppresses any same-cycle load-use stall.
//  - Load-use: idex mem-read & reg-write & idex_wr_reg!=0 & matches a used rs -> pc_hold,
//    ifid_hold, idex_bubble=1; next LOAD_STALL; exactly one stall cycle, then RUN.
//  - Forwarding: EX/MEM match (reg-write, rd!=0, rd==ID/EX source) beats MEM/WB match; x0 never
//    forwarded. Sources are ID/EX rs fields latched internally on each non-held, non-frozen clk.
//  - Reset mid-stall/wait: immediate return to RUN, no output glitch held past rst deassert.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs stall_cnt_o[31:0], flush_cnt_o[31:0], wait_cnt_o[31:0],
//  incremented once per cycle in LOAD_STALL-entry/flush/freeze, wrap at 2^32, reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  riscv_pipe_pkg: ctrl bit index localparams, fwd_sel codes (FWD_RF/FWD_EXMEM/FWD_MEMWB),
//  hazard state encoding. Sub-module fwd_sel_unit (one operand compare), instantiated for A and B.
// TESTING
//  lw x5 in ID/EX, add uses x5 in ID -> 1 cycle pc_hold/ifid_hold/bubble=1, then fwd_a=10.
//  lw x0 then use x0 -> no stall, fwd selects 00.
//  add x3 in EX/MEM and MEM/WB both writing x3, EX reads x3 -> fwd_a=01.
//  branch_taken with simultaneous load-use -> ifid_flush=1, bubble=1, pc_hold=0; FLUSH then RUN.
//  dmem_req with ready low 3 cycles -> freeze 3 cycles, release on 4th; perf wait_cnt=3 if EN.
//  rst asserted during MEM_WAIT -> all outputs 0 same cycle, state RUN after release.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants: ctrl-vector bit positions, forwarding select codes and
// hazard-controller state encoding.
package riscv_pipe_pkg;

  localparam int unsigned CTRL_WIDTH_DEF    = 16;
  localparam int unsigned MEM_READ_BIT_DEF  = 3;
  localparam int unsigned REG_WRITE_BIT_DEF = 0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    StRun       = 2'b00,
    StLoadStall = 2'b01,
    StFlush     = 2'b10,
    StMemWait   = 2'b11
  } hazard_state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one EX operand: youngest producer (EX/MEM) wins over MEM/WB,
// and x0 is never forwarded.
module fwd_sel_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic [4:0] exmem_wr_reg,
  input  logic       exmem_reg_write,
  input  logic [4:0] memwb_wr_reg,
  input  logic       memwb_reg_write,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (exmem_reg_write && (exmem_wr_reg != 5'd0) && (exmem_wr_reg == src_reg)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_wr_reg != 5'd0) && (memwb_wr_reg == src_reg)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard control: load-use stall, taken-branch flush, data-memory wait freeze and
// operand forwarding. Optional perf counters under HAZARD_PERF_CNT_EN.
module idex_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH    = CTRL_WIDTH_DEF,
  parameter int unsigned MEM_READ_BIT  = MEM_READ_BIT_DEF,
  parameter int unsigned REG_WRITE_BIT = REG_WRITE_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            id_rs1_i,
  input  logic [4:0]            id_rs2_i,
  input  logic [1:0]            id_rs_used_i,
  input  logic [4:0]            idex_wr_reg_i,
  input  logic [CTRL_WIDTH-1:0] idex_ctrl_i,
  input  logic [4:0]            exmem_wr_reg_i,
  input  logic [CTRL_WIDTH-1:0] exmem_ctrl_i,
  input  logic [4:0]            memwb_wr_reg_i,
  input  logic [CTRL_WIDTH-1:0] memwb_ctrl_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_hold_o,
  output logic                  ifid_hold_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  pipe_freeze_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
  output logic [31:0]           wait_cnt_o
`endif
);

  hazard_state_e state_q, state_d;
  logic [4:0]    src_rs1_q, src_rs2_q;
  logic          mem_wait, branch_flush, load_use, rs_hit;
  logic          pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze;
  logic [1:0]    fwd_a, fwd_b;
  logic          unused_ctrl;

  assign unused_ctrl = ^{idex_ctrl_i, exmem_ctrl_i, memwb_ctrl_i};

  assign rs_hit = (id_rs_used_i[0] && (id_rs1_i == idex_wr_reg_i)) ||
                  (id_rs_used_i[1] && (id_rs2_i == idex_wr_reg_i));

  always_comb begin
    mem_wait     = dmem_req_i & ~dmem_ready_i;
    branch_flush = ~mem_wait & branch_taken_i;
    // The bubble already sits in ID/EX while in LoadStall, so never stall twice in a row.
    load_use     = ~mem_wait & ~branch_taken_i & (state_q != StLoadStall) &
                   idex_ctrl_i[MEM_READ_BIT] & idex_ctrl_i[REG_WRITE_BIT] &
                   (idex_wr_reg_i != 5'd0) & rs_hit;

    state_d     = StRun;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;

    if (mem_wait) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      pipe_freeze = 1'b1;
      state_d     = StMemWait;
    end else if (branch_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StFlush;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StLoadStall;
    end
  end

  fwd_sel_unit u_fwd_a (
    .src_reg         (src_rs1_q),
    .exmem_wr_reg    (exmem_wr_reg_i),
    .exmem_reg_write (exmem_ctrl_i[REG_WRITE_BIT]),
    .memwb_wr_reg    (memwb_wr_reg_i),
    .memwb_reg_write (memwb_ctrl_i[REG_WRITE_BIT]),
    .fwd_sel         (fwd_a)
  );

  fwd_sel_unit u_fwd_b (
    .src_reg         (src_rs2_q),
    .exmem_wr_reg    (exmem_wr_reg_i),
    .exmem_reg_write (exmem_ctrl_i[REG_WRITE_BIT]),
    .memwb_wr_reg    (memwb_wr_reg_i),
    .memwb_reg_write (memwb_ctrl_i[REG_WRITE_BIT]),
    .fwd_sel         (fwd_b)
  );

  always_comb begin
    pc_hold_o     = pc_hold & ~rst;
    ifid_hold_o   = ifid_hold & ~rst;
    ifid_flush_o  = ifid_flush & ~rst;
    idex_bubble_o = idex_bubble & ~rst;
    pipe_freeze_o = pipe_freeze & ~rst;
    fwd_a_sel_o   = rst ? FWD_RF : fwd_a;
    fwd_b_sel_o   = rst ? FWD_RF : fwd_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow of the ID/EX source fields: follows ID whenever ID/EX is allowed to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_rs1_q <= 5'd0;
      src_rs2_q <= 5'd0;
    end else if (!ifid_hold && !pipe_freeze) begin
      src_rs1_q <= id_rs1_i;
      src_rs2_q <= id_rs2_i;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      if (load_use)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (mem_wait)     wait_cnt_q  <= wait_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign wait_cnt_o  = wait_cnt_q;
`endif

endmodule
